// File: rtl/conv_pkg.sv
// Shared constants, byte-lane map and FSM encoding for the 3x3 convolution MAC stage.
package conv_pkg;
  localparam int STREAM_W = 72;
  localparam int PIX_W    = 8;
  localparam int COEF_W   = 8;
  localparam int PROD_W   = 17;
  localparam int NUM_TAPS = 9;
  localparam int BIAS_W   = 24;

  localparam logic [3:0] ADDR_BIAS = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // LSB of the byte holding tap k = 3*row + col inside a window beat.
  function automatic int lane_lsb(input int k);
    case (k)
      0:       return 48;
      1:       return 24;
      2:       return 0;
      3:       return 56;
      4:       return 32;
      5:       return 8;
      6:       return 64;
      7:       return 40;
      default: return 16;
    endcase
  endfunction
endpackage

// File: rtl/conv3x3_mac_stage_if.sv
// Window-in / pixel-out stream bundle of the 3x3 MAC stage.
interface conv3x3_mac_stage_if;
  import conv_pkg::*;

  logic [STREAM_W-1:0] win_data;
  logic                win_valid;
  logic                win_rdy;
  logic [PIX_W-1:0]    pix_data;
  logic                pix_valid;
  logic                pix_rdy;

  modport master (output win_data, win_valid, pix_rdy,
                  input  win_rdy, pix_data, pix_valid);
  modport slave  (input  win_data, win_valid, pix_rdy,
                  output win_rdy, pix_data, pix_valid);
endinterface

// File: rtl/conv3x3_adder_tree.sv
// Two-cycle reduction of nine signed products plus bias: three 3-term partial sums, then final sum.
module conv3x3_adder_tree
  import conv_pkg::*;
#(
  parameter int ACC_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic                        vld_p1,
  input  logic signed [PROD_W-1:0]    prod_p1 [NUM_TAPS],
  input  logic signed [ACC_WIDTH-1:0] bias_p1,
  output logic signed [ACC_WIDTH-1:0] acc_p3,
  output logic                        vld_p3,
  output logic                        pipe_vld
);

  logic signed [ACC_WIDTH-1:0] psum_p2_d [3];
  logic signed [ACC_WIDTH-1:0] psum_p2_q [3];
  logic signed [ACC_WIDTH-1:0] bias_p2_d, bias_p2_q;
  logic signed [ACC_WIDTH-1:0] acc_p3_d, acc_p3_q;
  logic                        vld_p2_d, vld_p2_q;
  logic                        vld_p3_d, vld_p3_q;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [PROD_W-1:0] p);
    return ACC_WIDTH'(p);
  endfunction

  always_comb begin
    psum_p2_d = psum_p2_q;
    bias_p2_d = bias_p2_q;
    vld_p2_d  = vld_p2_q;
    acc_p3_d  = acc_p3_q;
    vld_p3_d  = vld_p3_q;
    if (en) begin
      // S2: partial sums per window row
      vld_p2_d = vld_p1;
      if (vld_p1) begin
        for (int g = 0; g < 3; g++)
          psum_p2_d[g] = sext(prod_p1[3*g]) + sext(prod_p1[3*g+1]) + sext(prod_p1[3*g+2]);
        bias_p2_d = bias_p1;
      end
      // S3: final sum plus bias
      vld_p3_d = vld_p2_q;
      if (vld_p2_q)
        acc_p3_d = psum_p2_q[0] + psum_p2_q[1] + psum_p2_q[2] + bias_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    psum_p2_q <= psum_p2_d;
    bias_p2_q <= bias_p2_d;
    acc_p3_q  <= acc_p3_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
  end

  assign acc_p3   = acc_p3_q;
  assign vld_p3   = vld_p3_q;
  assign pipe_vld = vld_p2_q | vld_p3_q;

endmodule

// File: rtl/conv3x3_mac_stage.sv
// 3x3 convolution MAC stage: weighted window sum + bias, then shift, ReLU and 8-bit saturation.
module conv3x3_mac_stage
  import conv_pkg::*;
#(
  parameter int STREAM_DATA_WIDTH = 72,
  parameter int ACC_WIDTH         = 24,
  parameter int SHIFT             = 8,
  parameter int DIM_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 Start,
  input  logic [DIM_WIDTH-1:0] input_layer_row_size,
  input  logic [DIM_WIDTH-1:0] input_layer_col_size,
  input  logic                 wgt_wr_en,
  input  logic [3:0]           wgt_wr_addr,
  input  logic [BIAS_W-1:0]    wgt_wr_data,
  conv3x3_mac_stage_if.slave   bus,
  output logic                 busy,
  output logic                 done
);

  if (STREAM_DATA_WIDTH != STREAM_W) begin : g_bad_width
    $error("conv3x3_mac_stage supports only a 72-bit window stream");
  end

  logic signed [COEF_W-1:0]    wgt_d [NUM_TAPS];
  logic signed [COEF_W-1:0]    wgt_q [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] bias_d, bias_q;
  logic signed [PROD_W-1:0]    prod_p1_d [NUM_TAPS];
  logic signed [PROD_W-1:0]    prod_p1_q [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] bias_p1_d, bias_p1_q;
  logic                        vld_p1_d, vld_p1_q;
  logic signed [ACC_WIDTH-1:0] acc_p3;
  logic                        vld_p3, pipe_vld;
  logic [PIX_W-1:0]            pix_data_d, pix_data_q;
  logic                        pix_valid_d, pix_valid_q;
  logic                        adv, win_rdy, acc_fire, pix_fire, pipe_empty;
  state_e                      state_q;
  logic [31:0]                 expected_q, accepted_q, emitted_q;
  logic                        busy_q, done_q;

  function automatic logic signed [PROD_W-1:0] mul(input logic [PIX_W-1:0] p,
                                                   input logic signed [COEF_W-1:0] w);
    logic signed [PROD_W-1:0] ps, ws;
    ps = {{(PROD_W-PIX_W){1'b0}}, p};
    ws = {{(PROD_W-COEF_W){w[COEF_W-1]}}, w};
    return ps * ws;
  endfunction

  function automatic logic [PIX_W-1:0] relu_sat(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] r;
    r = a >>> SHIFT;
    if (r < 0) return '0;
    if (r > ACC_WIDTH'(255)) return '1;
    return r[PIX_W-1:0];
  endfunction

  function automatic logic [31:0] run_len(input logic [DIM_WIDTH-1:0] r,
                                          input logic [DIM_WIDTH-1:0] c);
    if (r < DIM_WIDTH'(3) || c < DIM_WIDTH'(3)) return '0;
    return 32'(r - DIM_WIDTH'(2)) * 32'(c - DIM_WIDTH'(2));
  endfunction

  assign adv        = ~pix_valid_q | bus.pix_rdy;
  assign win_rdy    = (state_q == ST_RUN) & adv & (accepted_q < expected_q);
  assign acc_fire   = bus.win_valid & win_rdy;
  assign pix_fire   = pix_valid_q & bus.pix_rdy;
  assign pipe_empty = ~(vld_p1_q | pipe_vld | pix_valid_q);

  always_comb begin
    wgt_d  = wgt_q;
    bias_d = bias_q;
    if (wgt_wr_en) begin
      if (wgt_wr_addr == ADDR_BIAS)
        bias_d = ACC_WIDTH'($signed(wgt_wr_data));
      for (int k = 0; k < NUM_TAPS; k++)
        if (wgt_wr_addr == 4'(k)) wgt_d[k] = $signed(wgt_wr_data[COEF_W-1:0]);
    end
  end

  always_comb begin
    prod_p1_d   = prod_p1_q;
    bias_p1_d   = bias_p1_q;
    vld_p1_d    = vld_p1_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    if (adv) begin
      // S1: multiply; bias is captured with the window so later writes leave it alone
      vld_p1_d = acc_fire;
      if (acc_fire) begin
        for (int k = 0; k < NUM_TAPS; k++)
          prod_p1_d[k] = mul(bus.win_data[lane_lsb(k) +: PIX_W], wgt_q[k]);
        bias_p1_d = bias_q;
      end
      // S4: shift, ReLU, saturate
      pix_valid_d = vld_p3;
      if (vld_p3) pix_data_d = relu_sat(acc_p3);
    end
  end

  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
    bias_p1_q <= bias_p1_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_TAPS; k++) wgt_q[k] <= '0;
      bias_q      <= '0;
      vld_p1_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      wgt_q       <= wgt_d;
      bias_q      <= bias_d;
      vld_p1_q    <= vld_p1_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
    end
  end

  conv3x3_adder_tree #(.ACC_WIDTH(ACC_WIDTH)) u_tree (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (adv),
    .vld_p1   (vld_p1_q),
    .prod_p1  (prod_p1_q),
    .bias_p1  (bias_p1_q),
    .acc_p3   (acc_p3),
    .vld_p3   (vld_p3),
    .pipe_vld (pipe_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      expected_q <= '0;
      accepted_q <= '0;
      emitted_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (acc_fire) accepted_q <= accepted_q + 32'd1;
      if (pix_fire) emitted_q  <= emitted_q + 32'd1;
      case (state_q)
        ST_IDLE: if (Start) begin
          expected_q <= run_len(input_layer_row_size, input_layer_col_size);
          accepted_q <= '0;
          emitted_q  <= '0;
          busy_q     <= 1'b1;
          state_q    <= ST_RUN;
        end
        ST_RUN: if (accepted_q == expected_q) state_q <= ST_DRAIN;
        ST_DRAIN: if (pipe_empty && emitted_q == expected_q) begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.win_rdy   = win_rdy;
  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_data  = pix_data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
